// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the GMII Ethernet/IPv4/UDP receive and transmit
// paths: parser state encoding, protocol constants, header sizes, receive
// error codes and the CRC-32 constants.
// ---------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HDR,
        IP_HDR,
        UDP_HDR,
        PAYLOAD,
        PAD_FCS,
        DROP
    } rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam int unsigned PREAMBLE_MAX   = 7;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    localparam logic [15:0] ETH_HDR_BYTES  = 16'd14;
    localparam logic [15:0] IP_HDR_BYTES   = 16'd20;
    localparam logic [15:0] UDP_HDR_BYTES  = 16'd8;

    localparam logic [2:0]  ERR_CRC        = 3'd1;
    localparam logic [2:0]  ERR_TRUNC      = 3'd2;
    localparam logic [2:0]  ERR_GMII       = 3'd3;
    localparam logic [2:0]  ERR_LEN        = 3'd4;

    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY       = 32'hEDB8_8320;  // reflected 0x04C11DB7
    localparam logic [31:0] CRC_RESIDUE    = 32'hC704_DD7B;  // MSB-first form

    // The CRC register runs LSB-first; reversing it gives the MSB-first form
    // in which the good-frame residue is expressed.
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// ---------------------------------------------------------------------------
// eth_crc32_d8
// Combinational byte-wide CRC-32 (IEEE 802.3, reflected) update, shared by
// the receive and transmit paths.
//   crc_i  : current CRC register
//   data_i : byte to absorb (bit 0 first, as on the wire)
//   crc_o  : CRC register after absorbing data_i
// ---------------------------------------------------------------------------
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        logic [31:0] c;
        c = crc_i;
        for (int unsigned i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (((c[0] ^ data_i[i]) == 1'b1) ? CRC_POLY : '0);
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_udp_rx_gmii.sv
// ---------------------------------------------------------------------------
// eth_udp_rx_gmii
// GMII receiver that filters Ethernet II / IPv4 / UDP frames addressed to
// this node and streams the UDP payload with one cycle of latency.
//   clk125m, reset_n          : GMII rx clock, async active-low reset
//   gmii_rx_dv/rxd/rx_er      : GMII receive interface
//   local_mac/ip/port         : accepted destination MAC (or broadcast), IP, port
//   payload_valid_o/dat_o     : payload byte strobe and data
//   payload_sop/eop           : first / last payload byte markers
//   src_mac/ip/port, data_length : header fields of the last accepted frame
//   rx_done / rx_err          : end-of-frame pulses, rx_err_code qualifies rx_err
// ---------------------------------------------------------------------------
module eth_udp_rx_gmii
    import eth_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input  logic        clk125m,
    input  logic        reset_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_er,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [15:0] local_port,
    output logic        payload_valid_o,
    output logic [7:0]  payload_dat_o,
    output logic        payload_sop,
    output logic        payload_eop,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic [15:0] data_length,
    output logic        rx_done,
    output logic        rx_err,
    output logic [2:0]  rx_err_code
);

    // Index of the last byte of each field within its header.
    localparam logic [15:0] ETH_DST_END   = 16'd5;
    localparam logic [15:0] ETH_SRC_END   = 16'd11;
    localparam logic [15:0] IP_PROTO_IDX  = 16'd9;
    localparam logic [15:0] IP_SRC_END    = 16'd15;
    localparam logic [15:0] UDP_SPORT_END = 16'd1;
    localparam logic [15:0] UDP_DPORT_END = 16'd3;
    localparam logic [15:0] UDP_LEN_END   = 16'd5;
    localparam logic [15:0] MAX_PL        = 16'(MAX_PAYLOAD);

    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        dv_q;
    logic [31:0] crc_q, crc_d, crc_next;
    logic [47:0] sh_q, sh_d;
    logic [47:0] smac_p_q, smac_p_d;
    logic [31:0] sip_p_q, sip_p_d;
    logic [15:0] sport_p_q, sport_p_d;
    logic [15:0] ulen_q, ulen_d;
    logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [7:0]  dat_q, dat_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [15:0] src_port_q, src_port_d, dlen_q, dlen_d;
    logic        done_q, done_d, err_q, err_d;
    logic [2:0]  code_q, code_d;
    logic [47:0] word48;
    logic        bad_len;

    eth_crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (gmii_rxd),
        .crc_o  (crc_next)
    );

    // Multi-byte fields ending on the current byte, most significant byte first.
    assign word48  = {sh_q[39:0], gmii_rxd};
    assign bad_len = (ulen_q < 16'd9) || ((ulen_q - UDP_HDR_BYTES) > MAX_PL);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        sh_d       = gmii_rx_dv ? word48 : sh_q;
        smac_p_d   = smac_p_q;
        sip_p_d    = sip_p_q;
        sport_p_d  = sport_p_q;
        ulen_d     = ulen_q;
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        dat_d      = dat_q;
        src_mac_d  = src_mac_q;
        src_ip_d   = src_ip_q;
        src_port_d = src_port_q;
        dlen_d     = dlen_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        code_d     = code_q;

        if (gmii_rx_dv && (state_q inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD_FCS})) begin
            crc_d = crc_next;
        end

        unique case (state_q)
            IDLE: begin
                // Only a byte following an idle cycle may start a frame, so the
                // tail of a frame cut by reset is never mistaken for a preamble.
                if (gmii_rx_dv && !dv_q && (gmii_rxd == PREAMBLE_BYTE)) begin
                    state_d = PREAMBLE;
                    cnt_d   = 16'd1;
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end else if (gmii_rx_er) begin
                    err_d = 1'b1; code_d = ERR_GMII; state_d = DROP;
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_d = ETH_HDR;
                    cnt_d   = '0;
                    crc_d   = CRC_INIT;
                end else if ((gmii_rxd == PREAMBLE_BYTE) && (cnt_q < 16'(PREAMBLE_MAX))) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    state_d = DROP;
                end
            end
            ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD: begin
                cnt_d = cnt_q + 16'd1;
                if (!gmii_rx_dv) begin
                    err_d = 1'b1; code_d = ERR_TRUNC; state_d = IDLE;
                end else if (gmii_rx_er) begin
                    err_d = 1'b1; code_d = ERR_GMII; state_d = DROP;
                end else if (state_q == ETH_HDR) begin
                    if ((cnt_q == ETH_DST_END) && (word48 != local_mac) && (word48 != '1)) begin
                        state_d = DROP;
                    end
                    if (cnt_q == ETH_SRC_END) begin
                        smac_p_d = word48;
                    end
                    if (cnt_q == ETH_HDR_BYTES - 16'd1) begin
                        state_d = (word48[15:0] == ETHERTYPE_IPV4) ? IP_HDR : DROP;
                        cnt_d   = '0;
                    end
                end else if (state_q == IP_HDR) begin
                    if (((cnt_q == 16'd0) && (gmii_rxd != IP_VER_IHL)) ||
                        ((cnt_q == IP_PROTO_IDX) && (gmii_rxd != IP_PROTO_UDP))) begin
                        state_d = DROP;
                    end
                    if (cnt_q == IP_SRC_END) begin
                        sip_p_d = word48[31:0];
                    end
                    if (cnt_q == IP_HDR_BYTES - 16'd1) begin
                        state_d = (word48[31:0] == local_ip) ? UDP_HDR : DROP;
                        cnt_d   = '0;
                    end
                end else if (state_q == UDP_HDR) begin
                    if (cnt_q == UDP_SPORT_END) begin
                        sport_p_d = word48[15:0];
                    end
                    if ((cnt_q == UDP_DPORT_END) && (word48[15:0] != local_port)) begin
                        state_d = DROP;
                    end
                    if (cnt_q == UDP_LEN_END) begin
                        ulen_d = word48[15:0];
                    end
                    if (cnt_q == UDP_HDR_BYTES - 16'd1) begin
                        cnt_d = '0;
                        if (bad_len) begin
                            err_d = 1'b1; code_d = ERR_LEN; state_d = DROP;
                        end else begin
                            src_mac_d  = smac_p_q;
                            src_ip_d   = sip_p_q;
                            src_port_d = sport_p_q;
                            dlen_d     = ulen_q - UDP_HDR_BYTES;
                            state_d    = PAYLOAD;
                        end
                    end
                end else begin
                    valid_d = 1'b1;
                    dat_d   = gmii_rxd;
                    sop_d   = (cnt_q == 16'd0);
                    if (cnt_q == dlen_q - 16'd1) begin
                        eop_d   = 1'b1;
                        state_d = PAD_FCS;
                    end
                end
            end
            PAD_FCS: begin
                if (!gmii_rx_dv) begin
                    if (bitrev32(crc_q) == CRC_RESIDUE) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1; code_d = ERR_CRC;
                    end
                    state_d = IDLE;
                end else if (gmii_rx_er) begin
                    err_d = 1'b1; code_d = ERR_GMII; state_d = DROP;
                end
            end
            DROP: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk125m or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dv_q       <= 1'b1;
            crc_q      <= CRC_INIT;
            sh_q       <= '0;
            smac_p_q   <= '0;
            sip_p_q    <= '0;
            sport_p_q  <= '0;
            ulen_q     <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            dat_q      <= '0;
            src_mac_q  <= '0;
            src_ip_q   <= '0;
            src_port_q <= '0;
            dlen_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dv_q       <= gmii_rx_dv;
            crc_q      <= crc_d;
            sh_q       <= sh_d;
            smac_p_q   <= smac_p_d;
            sip_p_q    <= sip_p_d;
            sport_p_q  <= sport_p_d;
            ulen_q     <= ulen_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            dat_q      <= dat_d;
            src_mac_q  <= src_mac_d;
            src_ip_q   <= src_ip_d;
            src_port_q <= src_port_d;
            dlen_q     <= dlen_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign payload_valid_o = valid_q;
    assign payload_dat_o   = dat_q;
    assign payload_sop     = sop_q;
    assign payload_eop     = eop_q;
    assign src_mac         = src_mac_q;
    assign src_ip          = src_ip_q;
    assign src_port        = src_port_q;
    assign data_length     = dlen_q;
    assign rx_done         = done_q;
    assign rx_err          = err_q;
    assign rx_err_code     = code_q;

endmodule

// File: tb/tb_eth_udp_rx_gmii.sv
// ---------------------------------------------------------------------------
// tb_eth_udp_rx_gmii
// Scoreboard bench: each frame is built byte by byte (with its FCS), the
// expected payload bytes and end-of-frame pulse are queued from the frame
// acceptance rules, and a monitor pops and compares whenever the receiver
// produces a payload strobe or a pulse.
// ---------------------------------------------------------------------------
module tb_eth_udp_rx_gmii;

    localparam int          MAXP  = 1472;
    localparam logic [47:0] LMAC  = 48'h000a_3501_fec0;
    localparam logic [31:0] LIP   = 32'hC0A8_0002;
    localparam logic [15:0] LPORT = 16'd2599;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam int EV_BYTE = 0, EV_DONE = 1, EV_ERR = 2;

    logic        clk, reset_n;
    logic        gmii_rx_dv, gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic        payload_valid_o, payload_sop, payload_eop;
    logic [7:0]  payload_dat_o;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port, data_length;
    logic        rx_done, rx_err;
    logic [2:0]  rx_err_code;

    eth_udp_rx_gmii #(.MAX_PAYLOAD(MAXP)) dut (
        .clk125m(clk), .reset_n(reset_n),
        .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd), .gmii_rx_er(gmii_rx_er),
        .local_mac(LMAC), .local_ip(LIP), .local_port(LPORT),
        .payload_valid_o(payload_valid_o), .payload_dat_o(payload_dat_o),
        .payload_sop(payload_sop), .payload_eop(payload_eop),
        .src_mac(src_mac), .src_ip(src_ip), .src_port(src_port),
        .data_length(data_length),
        .rx_done(rx_done), .rx_err(rx_err), .rx_err_code(rx_err_code)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct {
        int          kind;
        logic [7:0]  data;
        logic        sop;
        logic        eop;
        logic [2:0]  code;
        logic        chk_hdr;
        logic [15:0] dlen;
        logic [31:0] sip;
        logic [15:0] sport;
        logic [47:0] smac;
    } ev_t;

    ev_t        exp_q[$];
    int         checks, failures;
    logic [7:0] fr[$];
    logic [7:0] pay[$];
    int         pay_start;

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (payload_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL payload_unexpected got=%02h sop=%0b eop=%0b want=no_output",
                             payload_dat_o, payload_sop, payload_eop);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_BYTE || payload_dat_o !== e.data ||
                        payload_sop !== e.sop || payload_eop !== e.eop) begin
                        failures++;
                        $display("FAIL payload_byte got=%02h sop=%0b eop=%0b want kind=%0d data=%02h sop=%0b eop=%0b",
                                 payload_dat_o, payload_sop, payload_eop, e.kind, e.data, e.sop, e.eop);
                    end
                end
            end
            if (rx_done || rx_err) begin
                checks++;
                if (rx_done && rx_err) begin
                    failures++;
                    $display("FAIL pulse_exclusive got done=1 err=1 want only one");
                end else if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pulse_unexpected got done=%0b err=%0b code=%0d want=none",
                             rx_done, rx_err, rx_err_code);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.kind == EV_DONE && !rx_done) || (e.kind == EV_ERR && !(rx_err && rx_err_code == e.code)) ||
                        e.kind == EV_BYTE) begin
                        failures++;
                        $display("FAIL pulse_kind got done=%0b err=%0b code=%0d want kind=%0d code=%0d",
                                 rx_done, rx_err, rx_err_code, e.kind, e.code);
                    end else if (e.chk_hdr && (data_length !== e.dlen || src_ip !== e.sip ||
                                               src_port !== e.sport || src_mac !== e.smac)) begin
                        failures++;
                        $display("FAIL header_fields got len=%0d ip=%08h port=%0d mac=%012h want len=%0d ip=%08h port=%0d mac=%012h",
                                 data_length, src_ip, src_port, src_mac, e.dlen, e.sip, e.sport, e.smac);
                    end
                end
            end
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({payload_valid_o, payload_dat_o, payload_sop, payload_eop, src_mac, src_ip,
             src_port, data_length, rx_done, rx_err, rx_err_code} != '0) begin
            failures++;
            $display("FAIL %s got valid=%0b dat=%02h len=%0d ip=%08h done=%0b err=%0b want all_zero",
                     name, payload_valid_o, payload_dat_o, data_length, src_ip, rx_done, rx_err);
        end
    endtask

    // cut_mode: 0 complete frame, 1 dv dropped after cut_after payload bytes,
    // 2 reset pulse after cut_after payload bytes, 3 rx_er on payload byte cut_after.
    task automatic run_frame(input logic [47:0] dmac, input logic [31:0] sip,
                             input logic [31:0] dip, input logic [15:0] sport,
                             input logic [15:0] dport, input int plen, input int pad,
                             input int ulen_ovr, input bit bad_fcs, input int cut_mode,
                             input int cut_after, input int gap);
        logic [7:0]  b[$];
        logic [47:0] smac;
        logic [15:0] ulen, tl, id;
        logic [31:0] c;
        int          npre, n;
        bit          accept;
        ev_t         e;

        smac = {16'h0200 | 16'($urandom_range(0, 255)), 32'($urandom)};
        ulen = (ulen_ovr >= 0) ? 16'(ulen_ovr) : 16'(plen + 8);
        tl   = 16'(28 + plen);
        id   = 16'($urandom);
        pay.delete();
        for (int i = 5; i >= 0; i--) b.push_back(dmac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) b.push_back(smac[i*8 +: 8]);
        b.push_back(8'h08); b.push_back(8'h00);
        b.push_back(8'h45); b.push_back(8'h00); b.push_back(tl[15:8]); b.push_back(tl[7:0]);
        b.push_back(id[15:8]); b.push_back(id[7:0]); b.push_back(8'h00); b.push_back(8'h00);
        b.push_back(8'h40); b.push_back(8'h11); b.push_back(8'h00); b.push_back(8'h00);
        for (int i = 3; i >= 0; i--) b.push_back(sip[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(dip[i*8 +: 8]);
        b.push_back(sport[15:8]); b.push_back(sport[7:0]);
        b.push_back(dport[15:8]); b.push_back(dport[7:0]);
        b.push_back(ulen[15:8]);  b.push_back(ulen[7:0]);
        b.push_back(8'h00); b.push_back(8'h00);
        for (int i = 0; i < plen; i++) begin
            pay.push_back(8'($urandom));
            b.push_back(pay[i]);
        end
        for (int i = 0; i < pad; i++) b.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c ^= {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) b.push_back(c[i*8 +: 8]);
        if (bad_fcs) b[b.size()-1] = b[b.size()-1] ^ 8'h01;

        fr.delete();
        npre = $urandom_range(1, 7);
        repeat (npre) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        foreach (b[i]) fr.push_back(b[i]);
        pay_start = npre + 1 + 42;

        // Expected behaviour from the acceptance rules.
        accept = (dmac == LMAC || dmac == BCAST) && dip == LIP && dport == LPORT;
        e.data = '0; e.sop = 0; e.eop = 0; e.code = '0; e.chk_hdr = 0;
        e.dlen = ulen - 16'd8; e.sip = sip; e.sport = sport; e.smac = smac;
        if (accept) begin
            if (ulen < 16'd9 || int'(ulen) - 8 > MAXP) begin
                e.kind = EV_ERR; e.code = 3'd4;
                exp_q.push_back(e);
            end else begin
                n = (cut_mode != 0) ? cut_after : plen;
                for (int i = 0; i < n; i++) begin
                    e.kind = EV_BYTE; e.data = pay[i];
                    e.sop = (i == 0); e.eop = (i == plen - 1);
                    exp_q.push_back(e);
                end
                e.sop = 0; e.eop = 0; e.data = '0; e.chk_hdr = 1;
                if (cut_mode == 0) begin
                    e.kind = bad_fcs ? EV_ERR : EV_DONE; e.code = bad_fcs ? 3'd1 : 3'd0;
                    exp_q.push_back(e);
                end else if (cut_mode == 1) begin
                    e.kind = EV_ERR; e.code = 3'd2; exp_q.push_back(e);
                end else if (cut_mode == 3) begin
                    e.kind = EV_ERR; e.code = 3'd3; exp_q.push_back(e);
                end
            end
        end

        for (int i = 0; i < fr.size(); i++) begin
            if (cut_mode == 1 && i == pay_start + cut_after) break;
            if (cut_mode == 2 && i == pay_start + cut_after) begin
                @(posedge clk);
                @(negedge clk);
                #1 reset_n = 1'b0;
                repeat (2) @(negedge clk);
                check_zero("reset_mid_frame");
                @(posedge clk);
                #1 reset_n = 1'b1;
            end
            @(posedge clk);
            #1;
            gmii_rx_dv = 1'b1;
            gmii_rxd   = fr[i];
            gmii_rx_er = (cut_mode == 3 && i == pay_start + cut_after);
        end
        @(posedge clk);
        #1;
        gmii_rx_dv = 1'b0; gmii_rxd = '0; gmii_rx_er = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        logic [47:0] dmac;
        logic [31:0] dip;
        logic [15:0] dport;
        int          r;

        checks = 0; failures = 0;
        reset_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rxd = '0; gmii_rx_er = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Good 1204-byte frame from 192.168.0.4:2599.
        run_frame(LMAC, 32'hC0A8_0004, LIP, 16'd2599, LPORT, 1204, 0, -1, 0, 0, 0, 12);
        // Wrong destination port: silent drop.
        run_frame(LMAC, 32'hC0A8_0004, LIP, 16'd2599, 16'd2600, 64, 0, -1, 0, 0, 0, 12);
        // Corrupted last FCS byte.
        run_frame(LMAC, 32'hC0A8_0004, LIP, 16'd2599, LPORT, 64, 0, -1, 1, 0, 0, 12);
        // dv dropped after 100 payload bytes.
        run_frame(LMAC, 32'hC0A8_0004, LIP, 16'd2599, LPORT, 1204, 0, -1, 0, 1, 100, 12);
        // Padded short frame followed by a broadcast frame.
        run_frame(LMAC, 32'hC0A8_0004, LIP, 16'd2599, LPORT, 4, 14, -1, 0, 0, 0, 12);
        run_frame(BCAST, 32'hC0A8_0009, LIP, 16'd1234, LPORT, 30, 0, -1, 0, 0, 0, 12);
        // Reset pulse mid-payload, then a good frame.
        run_frame(LMAC, 32'hC0A8_0004, LIP, 16'd2599, LPORT, 200, 0, -1, 0, 2, 50, 4);
        run_frame(LMAC, 32'hC0A8_0005, LIP, 16'd2599, LPORT, 48, 0, -1, 0, 0, 0, 6);
        // UDP length limits.
        run_frame(LMAC, 32'hC0A8_0004, LIP, 16'd2599, LPORT, 10, 0, 8, 0, 0, 0, 6);
        run_frame(LMAC, 32'hC0A8_0004, LIP, 16'd2599, LPORT, 10, 0, MAXP + 9, 0, 0, 0, 6);
        run_frame(LMAC, 32'hC0A8_0006, LIP, 16'd7, LPORT, 1, 0, -1, 0, 0, 0, 1);
        run_frame(LMAC, 32'hC0A8_0007, LIP, 16'd8, LPORT, MAXP, 0, -1, 0, 0, 0, 1);
        // Receive error mid-payload.
        run_frame(LMAC, 32'hC0A8_0004, LIP, 16'd2599, LPORT, 40, 0, -1, 0, 3, 17, 3);

        for (int f = 0; f < 12; f++) begin
            r     = $urandom_range(0, 9);
            dmac  = (r < 6) ? LMAC : (r < 8) ? BCAST : {16'h0200, 32'($urandom)};
            dip   = ($urandom_range(0, 9) == 0) ? (LIP ^ 32'h1) : LIP;
            dport = ($urandom_range(0, 4) == 0) ? (LPORT + 16'd1) : LPORT;
            run_frame(dmac, 32'($urandom), dip, 16'($urandom), dport,
                      $urandom_range(1, 80), $urandom_range(0, 10), -1,
                      ($urandom_range(0, 4) == 0), 0, 0, $urandom_range(1, 5));
        end

        repeat (20) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_udp_rx_gmii.md
ETH_UDP_RX_GMII -- requirements
Module: eth_udp_rx_gmii

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 1472, the largest UDP payload in bytes that is accepted.
REQ-002 SHALL have port clk125m, input, 1, the GMII receive clock and the only clock.
REQ-003 SHALL have port reset_n, input, 1, the reset (asynchronous, active-low).
REQ-004 SHALL have port gmii_rx_dv, input, 1, receive data valid.
REQ-005 SHALL have port gmii_rxd, input, 8, receive byte.
REQ-006 SHALL have port gmii_rx_er, input, 1, receive error.
REQ-007 SHALL have port local_mac, input, 48, the accepted destination MAC.
REQ-008 SHALL have port local_ip, input, 32, the accepted destination IP.
REQ-009 SHALL have port local_port, input, 16, the accepted UDP destination port.
REQ-010 SHALL have port payload_valid_o, output, 1, payload byte strobe.
REQ-011 SHALL have port payload_dat_o, output, 8, payload byte.
REQ-012 SHALL have ports payload_sop and payload_eop, outputs, 1 each, marking the first and last payload byte.
REQ-013 SHALL have ports src_mac (48), src_ip (32), src_port (16) and data_length (16), outputs, holding the header fields of the current frame.
REQ-014 SHALL have ports rx_done and rx_err, outputs, 1 each, both single-cycle pulses.
REQ-015 SHALL have port rx_err_code, output, 3: 1 = CRC, 2 = truncated, 3 = gmii_rx_er, 4 = length.

Function
REQ-016 SHALL use states IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD_FCS, DROP.
REQ-017 SHALL move from IDLE to PREAMBLE on gmii_rx_dv with gmii_rxd == 0x55.
- PREAMBLE accepts 1 to 7 bytes of 0x55 followed by 0xD5.
- Any other byte goes to DROP.
REQ-018 SHALL parse 14 bytes in ETH_HDR.
- Destination must equal local_mac or FF:FF:FF:FF:FF:FF.
- Ethertype must be 0x0800.
- Otherwise go to DROP.
REQ-019 SHALL parse 20 bytes in IP_HDR.
- Byte 0 must be 0x45, protocol must be 0x11, destination must equal local_ip.
- Otherwise go to DROP; the IP checksum is not checked.
REQ-020 SHALL parse 8 bytes in UDP_HDR.
- Destination port must equal local_port; otherwise go to DROP.
- If UDP length < 9 or (UDP length - 8) > MAX_PAYLOAD, pulse rx_err with code 4 and go to DROP.
REQ-021 SHALL update src_mac, src_ip, src_port and data_length (= UDP length - 8) at the end of UDP_HDR, and hold them until the next accepted header.
REQ-022 SHALL output each payload byte received in cycle N on payload_dat_o in cycle N+1, with payload_valid_o high (1-cycle latency).
- payload_sop accompanies the first byte; payload_eop accompanies byte data_length.
REQ-023 SHALL treat bytes after the payload in PAD_FCS as padding/FCS, not output them, and evaluate the CRC on the falling edge of gmii_rx_dv.
REQ-024 SHALL compute CRC-32 (IEEE, reflected, init 0xFFFFFFFF) over every byte from the destination MAC through the FCS; a good frame leaves the residue 0xC704DD7B.
REQ-025 SHALL, one cycle after gmii_rx_dv falls in PAD_FCS:
- pulse rx_done if the residue matches;
- otherwise pulse rx_err with code 1.
REQ-026 SHALL, if gmii_rx_dv falls in ETH_HDR through PAYLOAD, pulse rx_err with code 2, suppress payload_eop, and return to IDLE.
REQ-027 SHALL, on gmii_rx_er high during a frame, pulse rx_err with code 3 once and go to DROP.
REQ-028 SHALL stay in DROP until gmii_rx_dv is low, then go to IDLE.
- Address, type and port mismatches produce no pulse.
REQ-029 SHALL accept back-to-back frames separated by a gap of at least one cycle with gmii_rx_dv low.
REQ-030 SHALL keep rx_done and rx_err mutually exclusive.

Reset
REQ-031 SHALL, on reset_n low, asynchronously:
- set the state to IDLE;
- clear all outputs to 0;
- set the CRC register to 0xFFFFFFFF.
REQ-032 SHALL, when reset is asserted mid-frame, discard the frame and emit no pulses; after release, ignore bytes until gmii_rx_dv has been low for one cycle.

Structure
REQ-033 SHALL keep the following in the shared eth_pkg package: the state encoding, ETHERTYPE_IPV4 (0x0800), IP_PROTO_UDP (0x11), CRC_RESIDUE (0xC704DD7B), the header byte counts (14/20/8), and the error codes.
REQ-034 SHALL implement the per-byte CRC update as a single sub-module, eth_crc32_d8, shared with the transmit path.

Verification
REQ-035 SHALL cover a good frame: local 00:0a:35:01:fe:c0 / 192.168.0.2 / 2599, source 192.168.0.4 port 2599, 1204-byte payload -> 1204 valid strobes, sop and eop asserted once each, rx_done, data_length = 1204, src_ip = 0xC0A80004.
REQ-036 SHALL cover a wrong port: UDP destination port 2600 -> no payload_valid_o, no rx_done, no rx_err.
REQ-037 SHALL cover a bad CRC: last FCS byte XOR 0x01 -> all payload bytes delivered, then rx_err with code 1 and no rx_done.
REQ-038 SHALL cover truncation: gmii_rx_dv dropped after 100 payload bytes -> 100 strobes, no eop, rx_err with code 2.
REQ-039 SHALL cover padding and back-to-back frames: 4-byte payload with 14 pad bytes, then a second frame after 12 idle cycles -> 4 strobes then rx_done, and the second frame is also received correctly.
REQ-040 SHALL cover reset during PAYLOAD: reset_n pulsed low -> outputs 0, no pulses, and the next good frame is received correctly.
